// File: rtl/cpu_multi_cycle_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: FSM state
// encoding, opcode/funct values and small decode helpers.
package cpu_multi_cycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  // Halt is handled separately; this covers everything that proceeds to EXEC.
  function automatic logic instr_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_multi_cycle_regfile.sv
// 32 x 32-bit register file.
//  clk, rst_n        clock, asynchronous active-low clear of every register
//  ra1/rd1, ra2/rd2  asynchronous read ports for rs/rt
//  dbg_ra/dbg_rd     asynchronous debug read port
//  we, wa, wd        synchronous write port; writes to register 0 are dropped
module cpu_multi_cycle_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  dbg_ra,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] dbg_rd,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  // Register 0 is hard-wired, so no storage is built for it.
  assign regs[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    logic [31:0] r_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (we && (wa == 5'(gi))) begin
        r_q <= wd;
      end
    end
    assign regs[gi] = r_q;
  end

  assign rd1    = regs[ra1];
  assign rd2    = regs[ra2];
  assign dbg_rd = regs[dbg_ra];

endmodule

// File: rtl/cpu_multi_cycle.sv
// Multi-cycle MIPS-subset core with one shared req/ack memory port used for
// both instruction fetch and load/store.
//  clk, rst_n                      clock, asynchronous active-low reset
//  bus_req/we/addr/wdata           memory request, held until bus_ack
//  bus_rdata, bus_ack              memory response (ack may be combinational)
//  dbg_ra, dbg_rd                  debug register read port
//  halted, fault, instret          status: stopped, sticky fault, retire count
module cpu_multi_cycle
  import cpu_multi_cycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata,
  input  logic             bus_ack,
  input  logic [4:0]       dbg_ra,
  output logic [31:0]      dbg_rd,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      alu_out_q, alu_out_d;
  logic [31:0]      mdr_q, mdr_d;
  logic [31:0]      wait_q, wait_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic [4:0]  rf_wa;
  logic        rf_we;
  logic        timeout_hit;
  logic [31:0] alu_res;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = sext16(ir_q[15:0]);

  cpu_multi_cycle_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra1    (rs),
    .ra2    (rt),
    .dbg_ra (dbg_ra),
    .rd1    (rf_rd1),
    .rd2    (rf_rd2),
    .dbg_rd (dbg_rd),
    .we     (rf_we),
    .wa     (rf_wa),
    .wd     (rf_wd)
  );

  // Request is decoded from state and gated by rst_n so an aborted access
  // drops immediately when reset asserts.
  assign bus_req   = rst_n && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign bus_we    = (state_q == ST_MEM) && (op == OP_SW);
  assign bus_addr  = (state_q == ST_MEM) ? {alu_out_q[31:2], 2'b00} : pc_q;
  assign bus_wdata = b_q;
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;
  assign instret   = instret_q;

  // wait_q is nonzero only while stalled in FETCH/MEM, so it is always zero
  // on entry to either request state.
  assign timeout_hit = (TIMEOUT != 0) && ((wait_q + 32'd1) == 32'(TIMEOUT));

  assign rf_wa = (op == OP_RTYPE) ? rd : rt;
  assign rf_wd = (op == OP_LW) ? mdr_q : alu_out_q;

  always_comb begin
    alu_res = '0;
    case (funct)
      FN_ADD:  alu_res = a_q + b_q;
      FN_SUB:  alu_res = a_q - b_q;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_SLT:  alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    wait_d    = '0;
    fault_d   = fault_q;
    instret_d = instret_q;
    rf_we     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (bus_ack) begin
          ir_d    = bus_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_DECODE: begin
        a_d       = rf_rd1;
        b_d       = rf_rd2;
        alu_out_d = pc_q + (imm_sext << 2);
        if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (!instr_legal(op, funct)) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op)
          OP_RTYPE: begin
            alu_out_d = alu_res;
            state_d   = ST_WB;
          end
          OP_ADDI: begin
            alu_out_d = a_q + imm_sext;
            state_d   = ST_WB;
          end
          OP_LW, OP_SW: begin
            alu_out_d = a_q + imm_sext;
            state_d   = ST_MEM;
          end
          OP_BEQ, OP_BNE: begin
            // ALUOut already holds the branch target computed in DECODE.
            if ((a_q == b_q) ^ (op == OP_BNE)) pc_d = alu_out_q;
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_FETCH;
          end
          OP_J: begin
            pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_FETCH;
          end
          default: begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        if (bus_ack) begin
          if (op == OP_SW) begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = ST_FETCH;
          end else begin
            mdr_d   = bus_rdata;
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_WB: begin
        rf_we     = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_cpu_multi_cycle.sv
module tb_cpu_multi_cycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [4:0]  dbg_ra = 5'd0;
  logic [31:0] dbg_rd;
  logic        halted, fault;
  logic [31:0] instret;

  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  logic        ack_en = 1'b1;
  int          wait_states = 0;
  int          req_cnt, run_cnt;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          run;
  } txn_t;
  txn_t log_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  cpu_multi_cycle #(.RESET_PC(32'h0), .TIMEOUT(8), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .dbg_ra    (dbg_ra),
    .dbg_rd    (dbg_rd),
    .halted    (halted),
    .fault     (fault),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  // Memory with programmable wait states; ack is combinational once the
  // request has been held for wait_states cycles.
  assign bus_rdata = mem[bus_addr[9:2]];
  assign bus_ack   = bus_req && ack_en && (req_cnt == wait_states);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= prog;
      req_cnt <= 0;
      run_cnt <= 0;
    end else if (bus_req) begin
      if (bus_ack) begin
        log_q.push_back('{bus_addr, bus_we, bus_wdata, run_cnt + 1});
        if (bus_we) mem[bus_addr[9:2]] <= bus_wdata;
        req_cnt <= 0;
        run_cnt <= 0;
      end else begin
        req_cnt <= req_cnt + 1;
        run_cnt <= run_cnt + 1;
      end
    end
  end

  function automatic logic [31:0] i_t(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_t(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] j_t(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(output int cycles);
    cycles = 0;
    while (!halted && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    dbg_ra = idx[4:0];
    #1;
    v = dbg_rd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clear_prog();
    prog[0] = 32'h2001_0005;            // addi $1,$0,5
    prog[1] = i_t(6'h08, 5'd0, 5'd2, 16'd1);
    ack_en = 1'b1;
    wait_states = 0;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    ack_en = 1'b0;                      // stall the fetch at 0x4
    read_reg(1, v);
    n_tests++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL reset_pre_r1: got %h expected %h", v, 32'd5); end
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h4) begin
      n_fail++; $display("FAIL reset_pre_fetch: req=%b addr=%h expected req=1 addr=00000004", bus_req, bus_addr);
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_drop: got %b expected 0", bus_req); end
    n_tests++;
    if (bus_addr !== 32'h0 || instret !== 32'd0) begin
      n_fail++; $display("FAIL reset_pc_instret: addr=%h instret=%0d expected 0/0", bus_addr, instret);
    end
    n_tests++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: halted=%b fault=%b expected 0/0", halted, fault);
    end
    read_reg(1, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_r1_clear: got %h expected 0", v); end
    ack_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_release_fetch: req=%b addr=%h expected req=1 addr=00000000", bus_req, bus_addr);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_arith();
    logic [31:0] v;
    int cyc;
    clear_prog();
    prog[0] = i_t(6'h08, 5'd0, 5'd1, 16'd5);       // addi $1,$0,5
    prog[1] = i_t(6'h08, 5'd0, 5'd2, 16'hFFFD);    // addi $2,$0,-3
    prog[2] = r_t(5'd1, 5'd2, 5'd3, 6'h20);        // add $3,$1,$2
    prog[3] = r_t(5'd2, 5'd1, 5'd4, 6'h2A);        // slt $4,$2,$1
    prog[4] = HALT_I;
    wait_states = 0;
    do_reset();
    run_until_halt(cyc);
    n_tests++;
    if (cyc !== 18) begin n_fail++; $display("FAIL arith_cycles: got %0d expected 18", cyc); end
    n_tests++;
    if (instret !== 32'd4 || fault !== 1'b0) begin
      n_fail++; $display("FAIL arith_instret: instret=%0d fault=%b expected 4/0", instret, fault);
    end
    read_reg(2, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL arith_r2: got %h expected fffffffd", v); end
    read_reg(3, v);
    n_tests++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL arith_add: got %h expected 00000002", v); end
    read_reg(4, v);
    n_tests++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL arith_slt: got %h expected 00000001", v); end
    $display("[TB] test_arith done cycles=%0d", cyc);
  endtask

  task automatic test_memory();
    logic [31:0] v;
    int cyc, start, st_run, ld_run;
    logic [31:0] st_data;
    clear_prog();
    prog[0]  = j_t(32'h40);                        // keep data word 0x8 out of the program path
    prog[16] = i_t(6'h08, 5'd0, 5'd1, 16'd5);      // addi $1,$0,5
    prog[17] = i_t(6'h2B, 5'd0, 5'd1, 16'd8);      // sw $1,8($0)
    prog[18] = i_t(6'h23, 5'd0, 5'd5, 16'd8);      // lw $5,8($0)
    prog[19] = HALT_I;
    wait_states = 3;
    start = log_q.size();
    do_reset();
    run_until_halt(cyc);
    st_run = -1; ld_run = -1; st_data = 32'hx;
    for (int i = start; i < log_q.size(); i++) begin
      if (log_q[i].we && log_q[i].addr == 32'h8) begin st_run = log_q[i].run; st_data = log_q[i].wdata; end
      if (!log_q[i].we && log_q[i].addr == 32'h8) ld_run = log_q[i].run;
    end
    n_tests++;
    if (cyc !== 39) begin n_fail++; $display("FAIL mem_cycles: got %0d expected 39", cyc); end
    n_tests++;
    if (st_data !== 32'd5 || st_run !== 4) begin
      n_fail++; $display("FAIL mem_store: data=%h run=%0d expected 00000005/4", st_data, st_run);
    end
    n_tests++;
    if (ld_run !== 4) begin n_fail++; $display("FAIL mem_load_run: got %0d expected 4", ld_run); end
    n_tests++;
    if (mem[2] !== 32'd5) begin n_fail++; $display("FAIL mem_word8: got %h expected 00000005", mem[2]); end
    read_reg(5, v);
    n_tests++;
    if (v !== 32'd5 || instret !== 32'd4) begin
      n_fail++; $display("FAIL mem_lw_r5: r5=%h instret=%0d expected 00000005/4", v, instret);
    end
    wait_states = 0;
    $display("[TB] test_memory done cycles=%0d", cyc);
  endtask

  task automatic test_branch();
    logic [31:0] v;
    logic [31:0] exp_pc [7];
    int cyc, start, n;
    exp_pc = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h40, 32'h44};
    clear_prog();
    prog[0]  = i_t(6'h08, 5'd0, 5'd1, 16'd1);      // addi $1,$0,1
    prog[1]  = i_t(6'h08, 5'd0, 5'd2, 16'd1);      // addi $2,$0,1
    prog[2]  = i_t(6'h04, 5'd1, 5'd2, 16'd1);      // beq taken -> 0x10
    prog[3]  = i_t(6'h08, 5'd0, 5'd3, 16'd9);      // skipped
    prog[4]  = i_t(6'h05, 5'd1, 5'd2, 16'd5);      // bne not taken
    prog[5]  = j_t(32'h40);
    prog[6]  = i_t(6'h08, 5'd0, 5'd3, 16'd8);      // skipped
    prog[16] = i_t(6'h08, 5'd0, 5'd0, 16'd7);      // addi $0,$0,7
    prog[17] = HALT_I;
    wait_states = 0;
    start = log_q.size();
    do_reset();
    run_until_halt(cyc);
    n = log_q.size() - start;
    n_tests++;
    if (n !== 7) begin n_fail++; $display("FAIL branch_fetch_count: got %0d expected 7", n); end
    for (int i = 0; i < 7 && i < n; i++) begin
      n_tests++;
      if (log_q[start+i].addr !== exp_pc[i] || log_q[start+i].we !== 1'b0) begin
        n_fail++; $display("FAIL branch_pc%0d: got %h expected %h", i, log_q[start+i].addr, exp_pc[i]);
      end
    end
    n_tests++;
    if (cyc !== 23 || instret !== 32'd6) begin
      n_fail++; $display("FAIL branch_cycles: cycles=%0d instret=%0d expected 23/6", cyc, instret);
    end
    read_reg(3, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL branch_skip_r3: got %h expected 0", v); end
    read_reg(0, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL branch_r0: got %h expected 0", v); end
    $display("[TB] test_branch done cycles=%0d", cyc);
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    clear_prog();
    prog[0] = i_t(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = i_t(6'h08, 5'd0, 5'd2, 16'd6);
    wait_states = 0;
    ack_en = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    ack_en = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_tests++;
    if (halted !== 1'b0 || bus_req !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: halted=%b req=%b expected 0/1", halted, bus_req);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (halted !== 1'b1 || fault !== 1'b1 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fault: halted=%b fault=%b req=%b expected 1/1/0", halted, fault, bus_req);
    end
    read_reg(2, v);
    n_tests++;
    if (instret !== 32'd1 || v !== 32'd0) begin
      n_fail++; $display("FAIL timeout_state: instret=%0d r2=%h expected 1/0", instret, v);
    end
    ack_en = 1'b1;
    $display("[TB] test_timeout done");
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    int cyc, n;
    clear_prog();
    prog[0] = i_t(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = i_t(6'h3E, 5'd0, 5'd6, 16'd1);       // illegal opcode
    prog[2] = i_t(6'h08, 5'd0, 5'd7, 16'd1);
    wait_states = 0;
    do_reset();
    run_until_halt(cyc);
    n_tests++;
    if (cyc !== 6 || fault !== 1'b1 || instret !== 32'd1) begin
      n_fail++; $display("FAIL illegal_fault: cycles=%0d fault=%b instret=%0d expected 6/1/1", cyc, fault, instret);
    end
    read_reg(6, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL illegal_no_write: got %h expected 0", v); end
    n = log_q.size();
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (log_q.size() !== n || bus_req !== 1'b0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL illegal_quiet: new_txns=%0d req=%b halted=%b expected 0/0/1", log_q.size() - n, bus_req, halted);
    end
    $display("[TB] test_illegal done");
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_timeout();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
